gated_hold_bank: RTL

Parametrised, clocked multi-channel hold register bank: the synchronous, multi-channel successor to our single-bit transparent latch. Each of NCH channels holds a WIDTH-bit word captured from its data input under a per-channel enable. Each channel runs in level mode (follows data while enable is high, holds while low) or edge mode (captures once per enable rising edge). Per-channel valid, sticky-change and capture-count status feed downstream sampling and debug logic.

---
 rtl/gated_hold_bank_pkg.sv | 6 +
 rtl/hold_chan.sv | 40 ++++
 rtl/gated_hold_bank.sv | 35 +++
 3 files changed

// File: rtl/gated_hold_bank_pkg.sv
// gated_hold_bank_pkg: channel mode encodings and the default capture-counter width
package gated_hold_bank_pkg;
  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE = 1'b1;
  localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/hold_chan.sv
// hold_chan: one hold channel (in: clk rst_n mode enable data clr_chg; out: q valid changed cnt), level/edge capture, sticky change flag, saturating count
module hold_chan
  import gated_hold_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = DEF_CNT_W,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             enable,
  input  logic [WIDTH-1:0] data,
  input  logic             clr_chg,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             changed,
  output logic [CNT_W-1:0] cnt
);
  logic en_d;
  logic cap;
  assign cap = enable & ((mode == MODE_LEVEL) | ~en_d);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_d    <= 1'b0;
      q       <= RST_VAL;
      valid   <= 1'b0;
      changed <= 1'b0;
      cnt     <= '0;
    end else begin
      en_d    <= enable;
      changed <= (cap && data != q) ? 1'b1 : clr_chg ? 1'b0 : changed;
      if (cap) begin
        q     <= data;
        valid <= 1'b1;
        cnt   <= &cnt ? cnt : cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/gated_hold_bank.sv
// gated_hold_bank: NCH independent hold channels (in: clk rst_n mode enable data clr_chg; out: q_out valid changed cap_cnt), packing only
module gated_hold_bank
  import gated_hold_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH = 4,
  parameter int CNT_W = DEF_CNT_W,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       mode,
  input  logic [NCH-1:0]       enable,
  input  logic [NCH*WIDTH-1:0] data,
  input  logic [NCH-1:0]       clr_chg,
  output logic [NCH*WIDTH-1:0] q_out,
  output logic [NCH-1:0]       valid,
  output logic [NCH-1:0]       changed,
  output logic [NCH*CNT_W-1:0] cap_cnt
);
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    hold_chan #(.WIDTH(WIDTH), .CNT_W(CNT_W), .RST_VAL(RST_VAL)) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .mode   (mode[i]),
      .enable (enable[i]),
      .data   (data[i*WIDTH +: WIDTH]),
      .clr_chg(clr_chg[i]),
      .q      (q_out[i*WIDTH +: WIDTH]),
      .valid  (valid[i]),
      .changed(changed[i]),
      .cnt    (cap_cnt[i*CNT_W +: CNT_W])
    );
  end
endmodule
